reg_dump_reader: RTL
====================

# reg_dump_reader

Read-side sequencer for the 32×32 processor register file: on a start pulse it walks the file through both read ports, two registers per pass. It streams each (address, data) pair out over a valid/ready interface and accumulates an XOR checksum. It sits beside the datapath as a debug/verification port and drives the register file's RSaddr/RTaddr inputs, muxed in by the top level when busy_o is high. It is the read-side counterpart to the clocked write port.

## Interface
- REG_COUNT, 32, number of registers dumped starting at address 0; even, 2..32
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  reset, asynchronous, active-low
- start_i  input  1  dump request; sampled only in IDLE
- busy_o  output  1  high in READ, SEND0, SEND1 and DONE
- done_o  output  1  one-cycle pulse in DONE state
- RSaddr_o  output  ADDR_W  to register file RS read address (even register of current pair)
- RTaddr_o  output  ADDR_W  to register file RT read address (odd register of current pair)
- RSdata_i  input  DATA_W  combinational read data for RSaddr_o
- RTdata_i  input  DATA_W  combinational read data for RTaddr_o
- out_valid_o  output  1  output word valid
- out_ready_i  input  1  downstream accepts word
- out_addr_o  output  ADDR_W  register number of out_data_o
- out_data_o  output  DATA_W  register contents
- chk_o  output  DATA_W  XOR of all words accepted since last start

## Operation
- States: IDLE, READ, SEND0, SEND1, DONE.
- IDLE: start_i=1 at an edge -> READ. Pair index p cleared to 0 and chk_o cleared to 0 at the same edge.
- READ: RSaddr_o=2p, RTaddr_o=2p+1. At the edge, capture RSdata_i into buf0 and RTdata_i into buf1 -> SEND0.
- SEND0: out_valid_o=1, out_addr_o=2p, out_data_o=buf0. On out_valid_o&out_ready_i at an edge: chk_o ^= buf0 -> SEND1.
- SEND1: out_valid_o=1, out_addr_o=2p+1, out_data_o=buf1. On handshake: chk_o ^= buf1. If p==REG_COUNT/2-1 -> DONE, else p+1 -> READ.
- DONE: done_o=1 for exactly one cycle -> IDLE. chk_o holds its final value until the next accepted start.
- RSaddr_o/RTaddr_o hold 2p/2p+1 in all non-IDLE states and are 0 in IDLE.
- start_i is ignored outside IDLE; there is no queuing.
- Snapshot rule: each pair reflects register contents at its READ edge. A write during the dump to an already-captured register is not reflected.
- Valid/ready: once out_valid_o rises, out_valid_o, out_addr_o and out_data_o stay stable until the handshake. out_valid_o never depends combinationally on out_ready_i.
- p is ADDR_W-1 bits wide. The last pair never wraps p past REG_COUNT/2-1.

## Timing
- Reset values (rst_i low, immediate): state IDLE, p=0, buf0=buf1=0, busy_o=0, done_o=0, out_valid_o=0, out_addr_o=0, out_data_o=0, RSaddr_o=RTaddr_o=0, chk_o=0.
- Reset mid-dump aborts immediately to IDLE with the reset values above. No done_o is produced.
- Edge numbering: start accepted at edge E0, so READ is occupied in cycle E0–E1.
- With out_ready_i tied high, each pair takes 3 cycles. The first out_valid_o appears in the cycle after E1.
- REG_COUNT=32 with ready tied high: 32 handshakes over edges E2..E48 (2 per 3 edges). DONE occupies E48–E49, done_o is high in that cycle, and the block is back in IDLE after E49.
- Each cycle with out_ready_i low while valid adds exactly one cycle.
- start_i high in the DONE cycle is ignored. start_i high in the first IDLE cycle after it begins a new dump.

## Test plan
- Bench preloads the register file with R[n]=0x1000_0000+n and ties ready high; pulse start_i. Required: 32 words, addresses 0..31 in order, with data matching. done_o appears exactly at the E48 cycle and busy_o low after E49. chk_o = XOR of all 32 values = 0x0000_0000.
- Same preload, with out_ready_i low for 5 cycles while valid on word 7. Required: out_addr_o=7 and out_data_o=0x1000_0007 held stable for all 5 cycles, then accepted. done_o is delayed by exactly 5 cycles.
- R[3]=0xDEAD_BEEF and all other registers 0, REG_COUNT=32. Required: chk_o=0xDEAD_BEEF at done_o. A second start clears chk_o to 0 at acceptance and yields 0xDEAD_BEEF again.
- Write R[0]=0xAAAA_AAAA via the register-file write port during the SEND0 of pair 0. Required: the dump emits the captured old value for address 0 and the new value is unaffected.
- Assert rst_i low during the SEND1 of pair 4. Required: all outputs go to reset values asynchronously with no done_o. A restart produces the full 32-word sequence from address 0.
- Hold start_i high during the entire dump. Required: exactly one dump, then one done_o, then a new dump begins in the first IDLE cycle after DONE.

Source files
------------

// File: rtl/reg_dump_reader.sv
// Debug read-side sequencer: walks the register file two registers per pass and
// streams (address, data) pairs over valid/ready while accumulating an XOR checksum.
module reg_dump_reader #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] RSaddr_o,
  output logic [ADDR_W-1:0] RTaddr_o,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [DATA_W-1:0] chk_o
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StSend0,
    StSend1,
    StDone
  } state_e;

  localparam logic [ADDR_W-2:0] LastPair = (ADDR_W-1)'(REG_COUNT / 2 - 1);

  state_e              state_q;
  logic [ADDR_W-2:0]   pair_q;
  logic [DATA_W-1:0]   buf0_q;
  logic [DATA_W-1:0]   buf1_q;
  logic [DATA_W-1:0]   chk_q;
  logic                busy_q;
  logic                done_q;
  logic                valid_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [ADDR_W-1:0]   rs_addr_q;
  logic [ADDR_W-1:0]   rt_addr_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      pair_q     <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      chk_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q   <= StRead;
            pair_q    <= '0;
            chk_q     <= '0;
            busy_q    <= 1'b1;
            rs_addr_q <= '0;
            rt_addr_q <= ADDR_W'(1);
          end
        end
        StRead: begin
          // Snapshot both registers of the pair; later writes are not reflected.
          buf0_q     <= RSdata_i;
          buf1_q     <= RTdata_i;
          out_data_q <= RSdata_i;
          out_addr_q <= {pair_q, 1'b0};
          valid_q    <= 1'b1;
          state_q    <= StSend0;
        end
        StSend0: begin
          if (out_ready_i) begin
            chk_q      <= chk_q ^ buf0_q;
            out_addr_q <= {pair_q, 1'b1};
            out_data_q <= buf1_q;
            state_q    <= StSend1;
          end
        end
        StSend1: begin
          if (out_ready_i) begin
            chk_q   <= chk_q ^ buf1_q;
            valid_q <= 1'b0;
            if (pair_q == LastPair) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              pair_q    <= pair_q + 1'b1;
              rs_addr_q <= {pair_q + 1'b1, 1'b0};
              rt_addr_q <= {pair_q + 1'b1, 1'b1};
              state_q   <= StRead;
            end
          end
        end
        StDone: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          rs_addr_q <= '0;
          rt_addr_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign RSaddr_o    = rs_addr_q;
  assign RTaddr_o    = rt_addr_q;
  assign out_valid_o = valid_q;
  assign out_addr_o  = out_addr_q;
  assign out_data_o  = out_data_q;
  assign chk_o       = chk_q;

endmodule
